// File: rtl/detect_event_display.sv
`default_nettype none
// ============================================================================
// Module   : detect_event_display
// Brief    : Counts rising edges of the sequence-detector flag as a BCD digit
//            with a sticky overflow flag and drives a 7-segment display. The
//            decimal point flashes for FLASH_CYCLES clocks after each counted
//            detection. Pin-level clear and hold inputs are synchronised.
// Revision : 1.0 - initial release
// ============================================================================
module detect_event_display #(
    parameter int unsigned FLASH_CYCLES = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       det_in,
    input  logic       clr,
    input  logic       hold,
    output logic [7:0] seg_out,
    output logic [3:0] count_out,
    output logic       ovf
);

    // Timer must hold FLASH_CYCLES itself, hence the +1.
    localparam int unsigned       c_TIMER_W    = $clog2(FLASH_CYCLES + 1);
    localparam logic [c_TIMER_W-1:0] c_FLASH_LOAD = c_TIMER_W'(FLASH_CYCLES);
    localparam logic [c_TIMER_W-1:0] c_TIMER_ONE  = c_TIMER_W'(1);
    localparam logic [3:0]        c_COUNT_MAX  = 4'd9;

    logic                 r_det_q;
    logic                 r_clr_meta;
    logic                 r_clr_s;
    logic                 r_hold_meta;
    logic                 r_hold_s;
    logic [3:0]           r_count;
    logic                 r_ovf;
    logic [c_TIMER_W-1:0] r_flash;

    logic                 w_hit;
    logic [6:0]           w_digit;

    // Previous detector level; resets high so a flag already asserted at
    // reset release must drop before it can count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_det_q <= 1'b1;
        end else begin
            r_det_q <= det_in;
        end
    end

    assign w_hit = det_in & ~r_det_q;

    // Two-flop synchronisers for the asynchronous clear and hold pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_meta  <= 1'b0;
            r_clr_s     <= 1'b0;
            r_hold_meta <= 1'b0;
            r_hold_s    <= 1'b0;
        end else begin
            r_clr_meta  <= clr;
            r_clr_s     <= r_clr_meta;
            r_hold_meta <= hold;
            r_hold_s    <= r_hold_meta;
        end
    end

    // Counter, overflow and flash timer: clear wins, then an accepted hit,
    // otherwise the flash timer runs down (including when a hit is held off).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 4'd0;
            r_ovf   <= 1'b0;
            r_flash <= '0;
        end else if (r_clr_s) begin
            r_count <= 4'd0;
            r_ovf   <= 1'b0;
            r_flash <= '0;
        end else if (w_hit && !r_hold_s) begin
            if (r_count >= c_COUNT_MAX) begin
                r_count <= 4'd0;
                r_ovf   <= 1'b1;
            end else begin
                r_count <= r_count + 4'd1;
            end
            r_flash <= c_FLASH_LOAD;
        end else if (r_flash != '0) begin
            r_flash <= r_flash - c_TIMER_ONE;
        end
    end

    // BCD to segment pattern; anything outside 0-9 shows a dash.
    always_comb begin
        w_digit = 7'h40;
        case (r_count)
            4'd0:    w_digit = 7'h3F;
            4'd1:    w_digit = 7'h06;
            4'd2:    w_digit = 7'h5B;
            4'd3:    w_digit = 7'h4F;
            4'd4:    w_digit = 7'h66;
            4'd5:    w_digit = 7'h6D;
            4'd6:    w_digit = 7'h7D;
            4'd7:    w_digit = 7'h07;
            4'd8:    w_digit = 7'h7F;
            4'd9:    w_digit = 7'h6F;
            default: w_digit = 7'h40;
        endcase
    end

    assign seg_out   = {(r_flash != '0), w_digit};
    assign count_out = r_count;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_detect_event_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_detect_event_display
// Brief    : Directed self-checking bench for detect_event_display.
// Revision : 1.0 - initial release
// ============================================================================
module tb_detect_event_display;

    localparam int unsigned FLASH_CYCLES = 10;

    logic       clk;
    logic       rst_n;
    logic       det_in;
    logic       clr;
    logic       hold;
    logic [7:0] seg_out;
    logic [3:0] count_out;
    logic       ovf;

    int n_vec;
    int n_err;

    detect_event_display #(
        .FLASH_CYCLES (FLASH_CYCLES)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .det_in    (det_in),
        .clr       (clr),
        .hold      (hold),
        .seg_out   (seg_out),
        .count_out (count_out),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle just after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle detector pulse followed by one low cycle.
    task automatic pulse();
        det_in = 1'b1;
        tick(1);
        det_in = 1'b0;
        tick(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] exp_cnt;
        n_vec  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        det_in = 1'b1;
        clr    = 1'b0;
        hold   = 1'b0;

        // Reset values visible before any clock edge.
        #3;
        check("rst_seg", seg_out, 32'h3F);
        check("rst_cnt", count_out, 32'd0);
        check("rst_ovf", ovf, 32'd0);

        // Release with det_in already high: must not count.
        tick(2);
        rst_n = 1'b1;
        tick(5);
        check("idle_seg", seg_out, 32'h3F);
        check("idle_cnt", count_out, 32'd0);
        check("idle_ovf", ovf, 32'd0);

        // Long detector high: one count, dp lit for exactly FLASH_CYCLES.
        det_in = 1'b0;
        tick(1);
        det_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (i == 5) det_in = 1'b0;
            check("flash_on", seg_out, 32'h86);
        end
        tick(1);
        check("flash_off", seg_out, 32'h06);
        check("single_cnt", count_out, 32'd1);

        // Async reset back to zero, then 10 pulses wrap with overflow.
        rst_n = 1'b0;
        #2;
        check("rst2_cnt", count_out, 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        for (int i = 0; i < 10; i++) begin
            pulse();
            exp_cnt = 4'((i + 1) % 10);
            check("wrap_cnt", count_out, 32'(exp_cnt));
            check("wrap_ovf", ovf, (i == 9) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            pulse();
        end
        check("post_cnt", count_out, 32'd3);
        check("post_ovf", ovf, 32'd1);
        check("post_seg", seg_out[6:0], 32'h4F);

        // Retrigger every 4 cycles keeps dp high; falls 10 after last.
        tick(12);
        check("dp_idle", seg_out, 32'h4F);
        for (int p = 0; p < 3; p++) begin
            det_in = 1'b1;
            tick(1);
            check("retrig_dp", seg_out[7], 32'd1);
            det_in = 1'b0;
            for (int j = 0; j < 3; j++) begin
                tick(1);
                check("retrig_dp", seg_out[7], 32'd1);
            end
        end
        for (int j = 4; j < 10; j++) begin
            tick(1);
            check("tail_dp", seg_out[7], 32'd1);
        end
        tick(1);
        check("tail_dp_off", seg_out[7], 32'd0);
        check("retrig_cnt", count_out, 32'd6);

        // Hold blocks counting and flashing.
        hold = 1'b1;
        tick(2);
        for (int i = 0; i < 3; i++) begin
            pulse();
            check("hold_seg", seg_out, 32'h7D);
        end
        check("hold_cnt", count_out, 32'd6);

        // Clear with a coincident hit at the effective edge.
        hold = 1'b0;
        tick(3);
        clr = 1'b1;
        tick(2);
        det_in = 1'b1;
        tick(1);
        det_in = 1'b0;
        clr = 1'b0;
        check("clr_cnt", count_out, 32'd0);
        check("clr_ovf", ovf, 32'd0);
        check("clr_seg", seg_out, 32'h3F);

        // Reset mid-flash at count 7, then count again from 0.
        tick(3);
        for (int i = 0; i < 7; i++) begin
            pulse();
        end
        check("pre_rst_cnt", count_out, 32'd7);
        check("pre_rst_seg", seg_out, 32'h87);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_seg", seg_out, 32'h3F);
        check("mid_rst_cnt", count_out, 32'd0);
        check("mid_rst_ovf", ovf, 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        pulse();
        check("restart_cnt", count_out, 32'd1);
        check("restart_seg", seg_out, 32'h06 | 32'h80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/detect_event_display.md
# detect_event_display

Output stage that sits directly downstream of the serial sequence detector. It takes the detector's level-type "sequence found" flag, counts each new detection as a BCD digit (0–9) with a sticky overflow flag, and drives the TinyTapeout 7-segment display. The decimal point flashes for a programmable time after every counted detection. A pin-driven clear input and a pin-driven hold input are synchronised internally.

## Interface
- `FLASH_CYCLES`, default 10: number of clock cycles the decimal point stays lit after a counted detection. Legal range is 1 to 2^24−1.
- `clk`, input, 1 bit: system clock. All state is updated on the rising edge.
- `rst_n`, input, 1 bit: reset, asynchronous, active-low.
- `det_in`, input, 1 bit: detector flag, synchronous to `clk`. It may stay high for several cycles.
- `clr`, input, 1 bit: asynchronous pin input. Clears the count, the overflow flag and the flash while high.
- `hold`, input, 1 bit: asynchronous pin input. Freezes counting while high.
- `seg_out`, output, 8 bits: display drive, active-high.
  - [0]=a (top), [1]=b (upper-right), [2]=c (lower-right), [3]=d (bottom), [4]=e (lower-left), [5]=f (upper-left), [6]=g (middle), [7]=dp.
- `count_out`, output, 4 bits: current BCD count, 0–9.
- `ovf`, output, 1 bit: sticky flag, set on a 9→0 wrap.

## Operation
**Edge detection**
- `det_q` registers `det_in`. Its reset value is 1.
- `hit = det_in & ~det_q`. Only one hit is produced per rising edge of `det_in`, however long it stays high.
- Because `det_q` resets to 1, a `det_in` that is already high at reset release does not count. It must first go low.

**Synchronisers**
- `clr` and `hold` each pass through a 2-flop synchroniser. Both stages reset to 0.
- The synchronised signals are `clr_s` and `hold_s`.

**Counter and flash update, in priority order each cycle**
1. If `clr_s` = 1: count ← 0, `ovf` ← 0, flash timer ← 0. A hit in the same cycle is discarded.
2. Else if `hit` and `hold_s` = 0:
   - If count = 9: count ← 0 and `ovf` ← 1.
   - Otherwise: count ← count + 1.
   - Flash timer ← `FLASH_CYCLES`. This reloads even if the timer is already running.
3. Else if `hit` and `hold_s` = 1: the hit is dropped. Count, `ovf` and flash timer are unchanged, except that a running flash timer still decrements.
4. Flash timer: if it is non-zero and neither case 1 nor case 2 applied, it decrements by 1. It saturates at 0.

**Widths and output decode**
- Flash timer width is `$clog2(FLASH_CYCLES+1)`.
- Count is a 4-bit register that never holds a value above 9.
- `seg_out` is combinational from the registers.
  - [6:0] is the digit pattern: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - An unreachable count decodes to 0x40, a dash.
  - [7] = (flash timer ≠ 0).
- `count_out` is the count register. `ovf` is the overflow register.

## Timing
**Reset values** (`rst_n` low, effective immediately without a clock edge):
- count = 0, `ovf` = 0, flash timer = 0, `det_q` = 1, synchronisers = 0.
- `seg_out` = 0x3F, `count_out` = 0, `ovf` = 0.

**Latencies**
- `det_in` goes 0→1 and is sampled at edge k: the new count is visible after edge k (1-cycle latency). `seg_out[7]` rises after edge k and stays high for exactly `FLASH_CYCLES` cycles.
- `clr` or `hold` is high before edge k: it takes effect on the hit or counter decision at edge k+2.
- `clr` must be held for at least 3 cycles to guarantee a clear.

**Boundary conditions**
- Retrigger during a flash reloads the timer to the full `FLASH_CYCLES`, so dp stays continuously high.
- A 9→0 wrap and `clr_s` in the same cycle give count 0 with `ovf` = 0.
- If `rst_n` is asserted mid-flash or mid-count, all state returns to its reset value immediately. After release, counting restarts from 0.

## Test plan
- Reset, then idle for 5 cycles → `seg_out` = 0x3F, `count_out` = 0, `ovf` = 0. `det_in` held high through reset release → no count.
- `det_in` high for 6 cycles once, with `FLASH_CYCLES` = 10 → `count_out` = 1 after the first edge. `seg_out` = 0x86 for exactly 10 cycles, then 0x06. No second increment.
- 10 separate `det_in` pulses → counts 1 through 9, then 0. `ovf` = 1 after the 10th pulse and stays 1 after 3 more pulses (count = 3, `seg_out[6:0]` = 0x4F).
- Pulses 4 cycles apart with `FLASH_CYCLES` = 10 → `seg_out[7]` never drops between pulses and falls exactly 10 cycles after the last counted pulse.
- Assert `hold`, wait 2 cycles, send 3 pulses → count unchanged and no new flash. Assert `clr` for 3 cycles with a pulse coinciding at the effective edge → count 0, `ovf` 0, dp 0.
- Drop `rst_n` asynchronously mid-flash at count 7 → outputs go to the reset values without a clock edge. After release, one pulse → count 1.
